// File: rtl/pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// pipeline_stall_controller
//
// Sequencing controller for the 5-stage pipeline front end. It merges the
// load-use stall request, taken-branch flushes from EX and the multi-cycle
// mult/div handshake into one set of PC / IF_ID / ID_EX controls.
//
// Optional feature: define STALL_STATS_EN to compile in the saturating
// Stall_Count statistics counter. Without it Stall_Count is tied to zero and
// all other behaviour is identical.
//
// Parameters
//   MD_TIMEOUT  max MD_WAIT cycles before the mult/div is abandoned (>= 2)
//   CNT_W       width of the stall statistics counter
//
// Ports
//   clk              in   rising-edge clock
//   rst_n            in   asynchronous active-low reset
//   Load_Use_Hazard  in   stall request from hazard detection
//   Branch_Taken     in   branch/jump in EX resolved taken
//   MulDiv_ID        in   instruction in ID is mult/div
//   MulDiv_Done      in   mult/div result ready (pulse or level)
//   PC_Write         out  PC register enable (combinational)
//   IF_ID_Write      out  IF_ID register enable (combinational)
//   IF_ID_Flush      out  clear IF_ID to NOP (combinational)
//   ID_EX_Flush      out  insert bubble into ID_EX (combinational)
//   MulDiv_Start     out  registered one-cycle start pulse
//   Busy             out  registered, high whenever not in RUN
//   Timeout_Err      out  sticky mult/div timeout flag, cleared by reset only
//   Stall_Count      out  saturating count of cycles with PC_Write = 0
// ---------------------------------------------------------------------------
module pipeline_stall_controller #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Load_Use_Hazard,
  input  logic             Branch_Taken,
  input  logic             MulDiv_ID,
  input  logic             MulDiv_Done,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             MulDiv_Start,
  output logic             Busy,
  output logic             Timeout_Err,
  output logic [CNT_W-1:0] Stall_Count
);

  localparam int WCW = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MD_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_RUN        = 2'd0,
    S_MD_ISSUE   = 2'd1,
    S_MD_WAIT    = 2'd2,
    S_MD_RELEASE = 2'd3
  } state_t;

  state_t         r_state;
  logic           r_start;
  logic           r_busy;
  logic           r_timeout;
  logic [WCW-1:0] r_wait_cnt;

  logic w_pc_write;
  logic w_if_id_write;
  logic w_if_id_flush;
  logic w_id_ex_flush;
  logic w_md_detect;
  logic w_wait_last;

  assign w_wait_last = (r_wait_cnt == WAIT_LAST);

  // Combinational front-end controls (zero latency from state and inputs).
  // While rst_n is low the front end is released regardless of the inputs.
  always_comb begin
    w_pc_write    = 1'b1;
    w_if_id_write = 1'b1;
    w_if_id_flush = 1'b0;
    w_id_ex_flush = 1'b0;
    w_md_detect   = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_RUN: begin
          if (Branch_Taken) begin
            // Taken branch wins: squash both younger instructions, keep fetching.
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
          end else if (Load_Use_Hazard) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_id_ex_flush = 1'b1;
          end else if (MulDiv_ID) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_id_ex_flush = 1'b1;
            w_md_detect   = 1'b1;
          end
        end
        S_MD_ISSUE, S_MD_WAIT: begin
          w_pc_write    = 1'b0;
          w_if_id_write = 1'b0;
          w_id_ex_flush = 1'b1;
        end
        // Release lets the mult/div in ID advance to EX; hazards are not
        // re-evaluated in this cycle.
        S_MD_RELEASE: begin
          w_pc_write    = 1'b1;
          w_if_id_write = 1'b1;
        end
        default: begin
          w_pc_write    = 1'b1;
          w_if_id_write = 1'b1;
        end
      endcase
    end
  end

  // Sequencing FSM with registered Start / Busy / Timeout_Err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_RUN;
      r_start    <= 1'b0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
      r_wait_cnt <= '0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        S_RUN: begin
          if (w_md_detect) begin
            r_state    <= S_MD_ISSUE;
            r_start    <= 1'b1;
            r_busy     <= 1'b1;
            r_wait_cnt <= '0;
          end
        end
        S_MD_ISSUE: begin
          r_state    <= S_MD_WAIT;
          r_wait_cnt <= '0;
        end
        S_MD_WAIT: begin
          r_wait_cnt <= r_wait_cnt + WCW'(1);
          if (MulDiv_Done) begin
            // Done on the final allowed cycle still counts as a normal completion.
            r_state <= S_MD_RELEASE;
          end else if (w_wait_last) begin
            r_timeout <= 1'b1;
            r_state   <= S_MD_RELEASE;
          end
        end
        S_MD_RELEASE: begin
          r_state <= S_RUN;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_RUN;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef STALL_STATS_EN
  logic [CNT_W-1:0] r_stall_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Counts every cycle in which the PC is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (!w_pc_write) begin
      r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  assign Stall_Count = r_stall_cnt;
`else
  assign Stall_Count = '0;
`endif

  assign PC_Write     = w_pc_write;
  assign IF_ID_Write  = w_if_id_write;
  assign IF_ID_Flush  = w_if_id_flush;
  assign ID_EX_Flush  = w_id_ex_flush;
  assign MulDiv_Start = r_start;
  assign Busy         = r_busy;
  assign Timeout_Err  = r_timeout;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
module tb_pipeline_stall_controller;

  localparam int TO   = 8;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          lu = 1'b0;
  logic          br = 1'b0;
  logic          md = 1'b0;
  logic          done = 1'b0;
  logic          pc_write, if_id_write, if_id_flush, id_ex_flush;
  logic          md_start, busy, timeout_err;
  logic [CW-1:0] stall_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: m_t counts cycles since a mult/div was detected (0 = none),
  // m_rel marks the single release cycle after it ends.
  int m_t   = 0;
  bit m_rel = 1'b0;
  bit m_to  = 1'b0;
  int m_cnt = 0;

  pipeline_stall_controller #(.MD_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .Load_Use_Hazard(lu),
    .Branch_Taken   (br),
    .MulDiv_ID      (md),
    .MulDiv_Done    (done),
    .PC_Write       (pc_write),
    .IF_ID_Write    (if_id_write),
    .IF_ID_Flush    (if_id_flush),
    .ID_EX_Flush    (id_ex_flush),
    .MulDiv_Start   (md_start),
    .Busy           (busy),
    .Timeout_Err    (timeout_err),
    .Stall_Count    (stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_cnt(input int v);
`ifdef STALL_STATS_EN
    return v;
`else
    return 0;
`endif
  endfunction

  // Per-cycle compare against the model, then advance the model by one edge.
  always @(negedge clk) begin
    int e_pcw, e_ifw, e_iff, e_ief, e_st, e_busy, n_t;
    bit n_rel;
    if (!rst_n) begin
      chk("rst_pc_write", pc_write, 1);
      chk("rst_if_id_write", if_id_write, 1);
      chk("rst_if_id_flush", if_id_flush, 0);
      chk("rst_id_ex_flush", id_ex_flush, 0);
      chk("rst_start", md_start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_timeout", timeout_err, 0);
      chk("rst_count", stall_count, 0);
      m_t = 0; m_rel = 0; m_to = 0; m_cnt = 0;
    end else begin
      if (m_rel)             begin e_pcw=1; e_ifw=1; e_iff=0; e_ief=0; e_st=0; e_busy=1; end
      else if (m_t == 1)     begin e_pcw=0; e_ifw=0; e_iff=0; e_ief=1; e_st=1; e_busy=1; end
      else if (m_t >= 2)     begin e_pcw=0; e_ifw=0; e_iff=0; e_ief=1; e_st=0; e_busy=1; end
      else if (br)           begin e_pcw=1; e_ifw=1; e_iff=1; e_ief=1; e_st=0; e_busy=0; end
      else if (lu || md)     begin e_pcw=0; e_ifw=0; e_iff=0; e_ief=1; e_st=0; e_busy=0; end
      else                   begin e_pcw=1; e_ifw=1; e_iff=0; e_ief=0; e_st=0; e_busy=0; end
      chk("pc_write", pc_write, e_pcw);
      chk("if_id_write", if_id_write, e_ifw);
      chk("if_id_flush", if_id_flush, e_iff);
      chk("id_ex_flush", id_ex_flush, e_ief);
      chk("start", md_start, e_st);
      chk("busy", busy, e_busy);
      chk("timeout", timeout_err, m_to);
      chk("count", stall_count, exp_cnt(m_cnt));
      // Waiting cycle k (k = m_t-2) is the last allowed when k == TO-1.
      n_rel = (m_t >= 2) && (done || (m_t == TO + 1));
      if (m_t >= 2 && !done && m_t == TO + 1) m_to = 1'b1;
      if (n_rel)                                n_t = 0;
      else if (m_t >= 1)                        n_t = m_t + 1;
      else if (!m_rel && !br && !lu && md)      n_t = 1;
      else                                      n_t = 0;
      if (e_pcw == 0 && m_cnt < CMAX) m_cnt++;
      m_t   = n_t;
      m_rel = n_rel;
    end
  end

  // One cycle of stimulus; returns mid-cycle so literal checks see that cycle.
  task automatic drive(input bit i_lu, input bit i_br, input bit i_md, input bit i_done);
    @(posedge clk); #1;
    lu = i_lu; br = i_br; md = i_md; done = i_done;
    @(negedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
  endtask

  // Called mid-cycle; holds reset across a falling edge so the model sees it.
  task automatic do_reset();
    rst_n = 1'b0;
    lu = 0; br = 0; md = 0; done = 0;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    idle(1);
    chk("lit_idle_busy", busy, 0);
    chk("lit_idle_pcw", pc_write, 1);

    // Single-cycle load-use stall
    drive(1, 0, 0, 0);
    chk("lit_lu_pcw", pc_write, 0);
    chk("lit_lu_ifw", if_id_write, 0);
    chk("lit_lu_idex", id_ex_flush, 1);
    idle(1);
    chk("lit_lu_after_pcw", pc_write, 1);
    chk("lit_lu_count", stall_count, exp_cnt(1));
    drive(0, 0, 0, 1);
    chk("lit_done_in_run_busy", busy, 0);

    // Branch beats load-use and mult/div
    drive(1, 1, 1, 0);
    chk("lit_br_iff", if_id_flush, 1);
    chk("lit_br_idex", id_ex_flush, 1);
    chk("lit_br_pcw", pc_write, 1);
    chk("lit_br_ifw", if_id_write, 1);
    idle(1);
    chk("lit_br_busy", busy, 0);
    chk("lit_br_start", md_start, 0);

    do_reset();

    // Mult/div with Done 4 cycles after Start
    drive(0, 0, 1, 0);
    chk("lit_md_detect_pcw", pc_write, 0);
    idle(1);
    chk("lit_md_start", md_start, 1);
    chk("lit_md_busy", busy, 1);
    drive(0, 1, 0, 0);
    chk("lit_md_br_ignored_iff", if_id_flush, 0);
    chk("lit_md_br_ignored_pcw", pc_write, 0);
    chk("lit_md_start_pulse", md_start, 0);
    idle(2);
    drive(0, 0, 0, 1);
    drive(1, 0, 1, 0);
    chk("lit_md_rel_pcw", pc_write, 1);
    chk("lit_md_rel_idex", id_ex_flush, 0);
    chk("lit_md_rel_busy", busy, 1);
    idle(1);
    chk("lit_md_run_busy", busy, 0);
    chk("lit_md_count", stall_count, exp_cnt(6));
    chk("lit_md_timeout", timeout_err, 0);

    do_reset();

    // Timeout: Done never arrives
    drive(0, 0, 1, 0);
    idle(9);
    chk("lit_to_last_wait_pcw", pc_write, 0);
    idle(1);
    chk("lit_to_rel_pcw", pc_write, 1);
    chk("lit_to_flag", timeout_err, 1);
    idle(3);
    chk("lit_to_sticky", timeout_err, 1);
    chk("lit_to_count", stall_count, exp_cnt(10));

    // Reset in the middle of MD_WAIT
    drive(0, 0, 1, 0);
    idle(3);
    rst_n = 1'b0;
    #1;
    chk("lit_rst_busy", busy, 0);
    chk("lit_rst_start", md_start, 0);
    chk("lit_rst_pcw", pc_write, 1);
    chk("lit_rst_count", stall_count, 0);
    chk("lit_rst_timeout", timeout_err, 0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset while Start is high drops it asynchronously
    drive(0, 0, 1, 0);
    idle(1);
    chk("lit_issue_start", md_start, 1);
    rst_n = 1'b0;
    #1;
    chk("lit_issue_rst_start", md_start, 0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
    chk("lit_no_stale_start", md_start, 0);

    // Saturation: MulDiv_ID held with no Done
    for (int i = 0; i < 25; i++) drive(0, 0, 1, 0);
    idle(2);
    chk("lit_sat_count", stall_count, exp_cnt(CMAX));

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
